scalar_mult_ctrl: RTL and testbench
===================================

Name: scalar_mult_ctrl

Overview:
Control FSM for right-to-left binary (double-and-add) ECC scalar multiplication Q = k*P. Consumes one scalar bit per step from the key bit-shifter (LSB first), and issues COPY/ADD/DBL commands to the point-arithmetic unit over a start/done handshake. After each bit it returns a one-cycle step pulse that advances the shifter. Sits between the key shifter and the point-arithmetic datapath.

Parameters:
KEY_BITS, 32, scalar width; equals the number of bit steps per job
CNT_W, $clog2(KEY_BITS), bit-counter width

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, asynchronous, active-high
start  input  1  job request; accepted only in IDLE
k_bit  input  1  current scalar bit from key shifter (combinational there)
key_rst  output  1  one-cycle pulse; system ORs into shifter reset to return its index to 0
bit_done  output  1  one-cycle pulse; drives shifter done_from_control (advance index)
op_start  output  1  one-cycle command pulse to point unit
op_code  output  2  01=ADD (Q=Q+P), 10=DBL (P=2P), 11=COPY (Q=P); held from op_start until op_done
op_done  input  1  point unit completion pulse
busy  output  1  high from start acceptance through the cycle before done
done  output  1  one-cycle job-complete pulse
q_inf  output  1  Q is the point at infinity; valid when done=1, held until next start

Behaviour:
- Reset: state=IDLE, cnt=0, key_rst=0, bit_done=0, op_start=0, op_code=00, busy=0, done=0, q_inf=1. i_rst mid-job aborts immediately. No partial result. Next job starts clean.
- States: IDLE, CLR, SAMPLE, ISSUE_A, WAIT_A, ISSUE_D, WAIT_D, STEP, FIN.
- IDLE: start=1 -> CLR, busy=1, q_inf=1, cnt=0. start while not IDLE is ignored (no queueing).
- CLR (1 cycle): key_rst=1 -> SAMPLE.
- SAMPLE (1 cycle): latch k_bit into bit_r. If bit_r=1 -> ISSUE_A. Otherwise, if cnt==KEY_BITS-1 -> STEP, else -> ISSUE_D.
- ISSUE_A: op_start=1, op_code=COPY if q_inf=1, else ADD -> WAIT_A.
- WAIT_A: on op_done: q_inf<=0. Then if cnt==KEY_BITS-1 -> STEP (final DBL skipped), else -> ISSUE_D.
- ISSUE_D: op_start=1, op_code=DBL -> WAIT_D. WAIT_D: on op_done -> STEP.
- STEP (1 cycle): bit_done=1. If cnt==KEY_BITS-1 -> FIN, else cnt<=cnt+1 and -> SAMPLE. The shifter index updates at the end of STEP, so k_bit is valid in the following SAMPLE.
- FIN (1 cycle): done=1, busy=0 -> IDLE.
- op_done is ignored in ISSUE_* cycles and outside WAIT_*; an op_done arriving there is dropped with no state effect. Point-unit latency is unbounded; there is no timeout.
- Exactly KEY_BITS bit_done pulses per job. DBL count = KEY_BITS-1 every job. ADD+COPY count = popcount(k), with COPY at most once.
- Zero-latency case: minimum 2 cycles per op (issue + done in next cycle).

Decomposition:
- Shared package ecc_pkg: op-code constants OP_ADD=2'b01, OP_DBL=2'b10, OP_COPY=2'b11, and the FSM state encoding.
- No sub-module: single FSM plus counter. Registered outputs only, no combinational paths from inputs to outputs.

Test Plan:
- k=0, op_done 1 cycle after each op_start -> 31 DBL, 0 ADD/COPY, 32 bit_done pulses, done with q_inf=1.
- k=1 -> first op COPY, then 31 DBL, 0 ADD, q_inf=0 at done.
- k=0x80000000 -> 31 DBL, then a single COPY on bit 31 with no trailing DBL, q_inf=0.
- k=0xFFFFFFFF, op_done delay randomized 1-20 cycles -> 1 COPY, 31 ADD, 31 DBL in order COPY,DBL,(ADD,DBL)x30,ADD; op_code stable while each op is outstanding.
- k=5; start pulsed again mid-job and a spurious op_done injected during SAMPLE -> both ignored; sequence COPY,DBL,DBL,ADD,DBL then 28 DBL; exactly one done.
- i_rst asserted during WAIT_A at bit 10 -> all outputs return to reset values asynchronously; new start with k=3 completes correctly (COPY,DBL,ADD,DBL,...).

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: point-unit op codes and scalar-multiply FSM states.
package ecc_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_DBL  = 2'b10;
  localparam logic [1:0] OP_COPY = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_SAMPLE,
    S_ISSUE_A,
    S_WAIT_A,
    S_ISSUE_D,
    S_WAIT_D,
    S_STEP,
    S_FIN
  } state_t;

endpackage

// File: rtl/scalar_mult_ctrl.sv
// Right-to-left double-and-add sequencer: walks the key LSB first, issuing
// COPY/ADD/DBL to the point unit and pulsing bit_done once per key bit.
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int KEY_BITS = 32,
  parameter int CNT_W    = $clog2(KEY_BITS)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       start,
  input  logic       k_bit,
  output logic       key_rst,
  output logic       bit_done,
  output logic       op_start,
  output logic [1:0] op_code,
  input  logic       op_done,
  output logic       busy,
  output logic       done,
  output logic       q_inf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == LAST);

  // All outputs are registered; each pulse is raised on entry to the state
  // in which it must be visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      key_rst  <= 1'b0;
      bit_done <= 1'b0;
      op_start <= 1'b0;
      op_code  <= OP_NONE;
      busy     <= 1'b0;
      done     <= 1'b0;
      q_inf    <= 1'b1;
    end else begin
      key_rst  <= 1'b0;
      bit_done <= 1'b0;
      op_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CLR;
            busy    <= 1'b1;
            q_inf   <= 1'b1;
            cnt     <= '0;
            key_rst <= 1'b1;
          end
        end
        S_CLR: state <= S_SAMPLE;
        S_SAMPLE: begin
          // The sampled bit is consumed here directly; no later state needs it.
          if (k_bit) begin
            op_start <= 1'b1;
            op_code  <= q_inf ? OP_COPY : OP_ADD;
            state    <= S_ISSUE_A;
          end else if (last) begin
            bit_done <= 1'b1;
            state    <= S_STEP;
          end else begin
            op_start <= 1'b1;
            op_code  <= OP_DBL;
            state    <= S_ISSUE_D;
          end
        end
        S_ISSUE_A: state <= S_WAIT_A;
        S_WAIT_A: begin
          if (op_done) begin
            q_inf <= 1'b0;
            // The top bit needs no doubling after it.
            if (last) begin
              bit_done <= 1'b1;
              state    <= S_STEP;
            end else begin
              op_start <= 1'b1;
              op_code  <= OP_DBL;
              state    <= S_ISSUE_D;
            end
          end
        end
        S_ISSUE_D: state <= S_WAIT_D;
        S_WAIT_D: begin
          if (op_done) begin
            bit_done <= 1'b1;
            state    <= S_STEP;
          end
        end
        S_STEP: begin
          if (last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            cnt   <= cnt + ONE;
            state <= S_SAMPLE;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: key-shifter and point-unit models plus an
// expected-op-sequence model derived from the double-and-add algorithm.
module tb_scalar_mult_ctrl;
  import ecc_pkg::*;

  localparam int KB = 32;
  typedef logic [1:0] opq_t[$];

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       start = 1'b0;
  logic       k_bit;
  logic       key_rst, bit_done, op_start, op_done, busy, done, q_inf;
  logic [1:0] op_code;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  scalar_mult_ctrl #(.KEY_BITS(KB)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .start    (start),
    .k_bit    (k_bit),
    .key_rst  (key_rst),
    .bit_done (bit_done),
    .op_start (op_start),
    .op_code  (op_code),
    .op_done  (op_done),
    .busy     (busy),
    .done     (done),
    .q_inf    (q_inf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected command stream: one COPY/ADD per set bit (first is COPY), one DBL after every bit but the last.
  task automatic build_model(input logic [31:0] k, output opq_t q);
    bit have_q;
    have_q = 1'b0;
    q = {};
    for (int i = 0; i < KB; i++) begin
      if (k[i]) begin
        q.push_back(have_q ? OP_ADD : OP_COPY);
        have_q = 1'b1;
      end
      if (i < KB - 1) q.push_back(OP_DBL);
    end
  endtask

  // Key shifter: combinational bit select, index cleared by key_rst, advanced by bit_done.
  logic [31:0] job_key = '0;
  logic [4:0]  idx;
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         idx <= '0;
    else if (key_rst)  idx <= '0;
    else if (bit_done) idx <= idx + 5'd1;
  end
  assign k_bit = job_key[idx];

  // Point unit: completes pu_lat cycles after seeing op_start (or a random 1..20).
  int   pu_lat  = 1;
  bit   pu_rand = 1'b0;
  int   pu_cnt  = 0;
  logic pu_done = 1'b0;
  logic spur_done = 1'b0;
  always @(negedge i_clk) begin
    if (i_rst) begin
      pu_cnt  = 0;
      pu_done = 1'b0;
    end else begin
      pu_done = 1'b0;
      if (pu_cnt > 0) begin
        pu_cnt--;
        if (pu_cnt == 0) pu_done = 1'b1;
      end
      if (op_start) pu_cnt = pu_rand ? int'($urandom_range(20, 1)) : pu_lat;
    end
  end
  assign op_done = pu_done | spur_done;

  // Compare process: checks every command, hold, step pulse and completion.
  int   job_seq = 0;
  bit   mon_en  = 1'b0;
  int   seen_job = 0;
  opq_t exp_q;
  bit   outst = 1'b0;
  logic [1:0] held = '0;
  int   bd_cnt = 0;
  int   done_cnt = 0;
  always @(negedge i_clk) begin
    #1;
    if (job_seq != seen_job) begin
      seen_job = job_seq;
      build_model(job_key, exp_q);
      outst    = 1'b0;
      bd_cnt   = 0;
      done_cnt = 0;
    end
    if (mon_en && !i_rst) begin
      if (outst) begin
        check("op_code_held", op_code, held);
        check("no_issue_while_outstanding", op_start, 1'b0);
        if (op_done) outst = 1'b0;
      end else if (op_start) begin
        check("busy_during_op", busy, 1'b1);
        check("op_available", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("op_code_seq", op_code, exp_q.pop_front());
          held  = op_code;
          outst = 1'b1;
        end
      end
      if (bit_done) begin
        bd_cnt++;
        check("bit_done_idle_unit", outst, 1'b0);
        check("busy_at_step", busy, 1'b1);
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 1'b0);
        check("done_q_inf", q_inf, job_key == 0);
        check("done_ops_left", exp_q.size(), 0);
        check("done_bit_pulses", bd_cnt, KB);
      end
    end
  end

  task automatic start_job(input logic [31:0] k, input int lat, input bit rnd);
    job_key = k;
    pu_lat  = lat;
    pu_rand = rnd;
    job_seq++;
    mon_en  = 1'b1;
    @(negedge i_clk);
    start = 1'b1;
    @(negedge i_clk);
    start = 1'b0;
  endtask

  task automatic finish_job(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge i_clk);
      #2;
      n++;
    end
    check("job_completes", done_cnt != 0, 1'b1);
    repeat (6) @(negedge i_clk);
    #2;
    check("single_done", done_cnt, 1);
    check("total_bit_done", bd_cnt, KB);
    mon_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_rst"}, key_rst, 1'b0);
    check({tag, "_bit_done"}, bit_done, 1'b0);
    check({tag, "_op_start"}, op_start, 1'b0);
    check({tag, "_op_code"}, op_code, OP_NONE);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_q_inf"}, q_inf, 1'b1);
  endtask

  opq_t pin_q;

  initial begin
    int n;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;

    // Hand-computed pins on the model itself.
    build_model(32'h0, pin_q);
    check("model_k0_len", pin_q.size(), 31);
    build_model(32'h1, pin_q);
    check("model_k1_len", pin_q.size(), 32);
    check("model_k1_first", pin_q[0], OP_COPY);
    build_model(32'h8000_0000, pin_q);
    check("model_msb_last", pin_q[31], OP_COPY);
    check("model_msb_prev", pin_q[30], OP_DBL);
    build_model(32'hFFFF_FFFF, pin_q);
    check("model_ones_len", pin_q.size(), 63);
    check("model_ones_2", pin_q[2], OP_ADD);
    check("model_ones_last", pin_q[62], OP_ADD);
    build_model(32'h5, pin_q);
    check("model_k5_len", pin_q.size(), 33);
    check("model_k5_3", pin_q[3], OP_ADD);

    // Zero key, minimum point-unit latency.
    start_job(32'h0, 1, 1'b0);
    finish_job(1000);
    // Single low bit.
    start_job(32'h1, 1, 1'b0);
    finish_job(1000);
    // Only the top bit set: final COPY with no trailing DBL.
    start_job(32'h8000_0000, 2, 1'b0);
    finish_job(1000);
    // All ones with random point-unit latency.
    start_job(32'hFFFF_FFFF, 1, 1'b1);
    finish_job(4000);

    // k=5: repeated start and a stray op_done in a SAMPLE cycle are ignored.
    start_job(32'h5, 3, 1'b0);
    n = 0;
    while (!(bit_done && bd_cnt >= 2) && n < 1000) begin
      @(negedge i_clk);
      #2;
      n++;
    end
    check("found_step", bit_done, 1'b1);
    @(negedge i_clk);
    spur_done = 1'b1;
    start     = 1'b1;
    @(negedge i_clk);
    spur_done = 1'b0;
    start     = 1'b0;
    finish_job(1000);

    // Abort during WAIT_A at bit 10, then a clean job.
    start_job(32'h0000_0401, 6, 1'b0);
    n = 0;
    while (!(bd_cnt == 10 && op_start) && n < 2000) begin
      @(negedge i_clk);
      #2;
      n++;
    end
    check("found_bit10_add", op_start && bd_cnt == 10, 1'b1);
    @(posedge i_clk);
    #3;
    mon_en = 1'b0;
    i_rst  = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    build_model(32'h3, pin_q);
    check("model_k3_2", pin_q[2], OP_ADD);
    start_job(32'h3, 1, 1'b0);
    finish_job(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
